// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron (Q8.8) behind a Tiny-Tapeout 8-bit pin interface.
// A 16-slot load sequence after reset sets the parameters, then v is updated once per clock.
module lif_neuron (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 5;
  localparam int unsigned PW = 34;
  localparam int unsigned XW = 18;
  localparam logic [SW-1:0] RUN_SLOT = SW'(16);

  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] e_rest_q, e_rest_d;
  logic [DW-1:0] tau_q, tau_d;
  logic [DW-1:0] v_th_q, v_th_d;
  logic [DW-1:0] v_init_q, v_init_d;
  logic [DW-1:0] v_q, v_d;
  logic          spike_q, spike_d;

  logic [DW-1:0]        cfg_w;
  logic signed [DW:0]   diff;
  logic signed [PW-1:0] diff_x, tau_x, prod, leak_x, v_x, i_x;
  logic signed [XW-1:0] sum;
  logic signed [DW-1:0] s_sat;
  logic                 fire;
  logic                 run;

  // Membrane update: leak toward rest, add input current, saturate, threshold.
  always_comb begin
    cfg_w  = {ui_in, uio_in};
    run    = (slot_q >= RUN_SLOT);
    diff   = $signed({e_rest_q[DW-1], e_rest_q}) - $signed({v_q[DW-1], v_q});
    diff_x = PW'(diff);
    tau_x  = $signed({18'd0, tau_q});
    prod   = diff_x * tau_x;
    leak_x = prod >>> 16;
    v_x    = PW'($signed(v_q));
    i_x    = PW'({ui_in, 5'b00000});
    sum    = XW'(leak_x + v_x + i_x);
    if (sum > 18'sd32767) begin
      s_sat = 16'sh7FFF;
    end else if (sum < -18'sd32768) begin
      s_sat = 16'sh8000;
    end else begin
      s_sat = sum[DW-1:0];
    end
    fire = (s_sat >= $signed(v_th_q));
  end

  // Slot sequencing, parameter capture and run-mode state update.
  always_comb begin
    slot_d   = slot_q;
    e_rest_d = e_rest_q;
    tau_d    = tau_q;
    v_th_d   = v_th_q;
    v_init_d = v_init_q;
    v_d      = v_q;
    spike_d  = spike_q;
    if (run) begin
      if (fire) begin
        v_d     = e_rest_q;
        spike_d = 1'b1;
      end else begin
        v_d     = s_sat;
        spike_d = 1'b0;
      end
    end else begin
      slot_d = slot_q + SW'(1);
      case (slot_q)
        SW'(1), SW'(2): e_rest_d = cfg_w;
        SW'(3):         tau_d    = cfg_w;
        SW'(4), SW'(5): v_th_d   = cfg_w;
        SW'(15):        v_d      = v_init_q;
        default: begin
          if (slot_q >= SW'(6) && slot_q <= SW'(14)) v_init_d = cfg_w;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      e_rest_q <= '0;
      tau_q    <= '0;
      v_th_q   <= '0;
      v_init_q <= '0;
      v_q      <= '0;
      spike_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      e_rest_q <= e_rest_d;
      tau_q    <= tau_d;
      v_th_q   <= v_th_d;
      v_init_q <= v_init_d;
      v_q      <= v_d;
      spike_q  <= spike_d;
    end
  end

  always_comb begin
    uo_out  = v_q[15:8];
    uio_out = {v_q[7:1], spike_q};
    uio_oe  = run ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: fixed first-step vectors, long hand sequences and random runs
// checked against an integer-arithmetic model of the neuron equations.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  int m_v, m_erest, m_tau, m_vth, m_spike;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [15:0] er;
    logic [15:0] tau;
    logic [15:0] vth;
    logic [15:0] vinit;
    logic [7:0]  ui;
    logic [15:0] exp_v;
    logic        exp_spk;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pins(input int v, input int spk, input bit run);
    logic [15:0] vb;
    vb = 16'(v);
    return {vb[15:8], vb[7:1], (spk != 0), (run ? 8'hFF : 8'h00)};
  endfunction

  function automatic logic [23:0] pins();
    return {uo_out, uio_out, uio_oe};
  endfunction

  // Neuron equations in plain integer arithmetic; leak is floor(d*tau/65536).
  function automatic void model_step(input int cur);
    longint d, p, lk, s;
    d  = longint'(m_erest) - longint'(m_v);
    p  = d * longint'(m_tau);
    lk = (p >= 0) ? (p / 65536) : -((-p + 65535) / 65536);
    s  = longint'(m_v) + lk + longint'(cur) * 32;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (s >= longint'(m_vth)) begin
      m_v     = m_erest;
      m_spike = 1;
    end else begin
      m_v     = int'(s);
      m_spike = 0;
    end
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    @(posedge clk); #1;
    rst     = 1'b0;
    m_v     = 0;
    m_spike = 0;
    m_erest = 0;
    m_tau   = 0;
    m_vth   = 0;
  endtask

  // Slot 1, 4 and 6..13 get random words so only the last write of each group matters.
  task automatic load_cfg(input logic [15:0] er, input logic [15:0] tau,
                          input logic [15:0] vth, input logic [15:0] vinit, input bit chk_oe);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) begin
      w = 16'($urandom);
      if (k == 2)       w = er;
      else if (k == 3)  w = tau;
      else if (k == 5)  w = vth;
      else if (k == 14) w = vinit;
      {ui_in, uio_in} = w;
      @(posedge clk); #1;
      if (chk_oe && k < 15) check("load_oe", 32'(uio_oe), 32'h00);
    end
    m_erest = int'($signed(er));
    m_tau   = int'(tau);
    m_vth   = int'($signed(vth));
    m_v     = int'($signed(vinit));
    m_spike = 0;
  endtask

  task automatic run_cycle(input logic [7:0] cur, input string tag, output bit ok);
    ui_in  = cur;
    uio_in = 8'($urandom);
    @(posedge clk); #1;
    model_step(int'(cur));
    ok = (pins() === exp_pins(m_v, m_spike, 1'b1));
    check(tag, 32'(pins()), 32'(exp_pins(m_v, m_spike, 1'b1)));
  endtask

  initial begin
    bit          ok;
    bit          mono_ok;
    bit          any_spike;
    int          spikes, m_spikes;
    logic [15:0] prev_v, cur_v;

    rst    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    vecs[0] = '{16'hC5FF, 16'h018E, 16'h3C00, 16'hE001, 8'h00, 16'hDFD8, 1'b0};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0200, 16'h0100, 8'h08, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0201, 16'h0100, 8'h08, 16'h0200, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7F00, 8'hFF, 16'h0000, 1'b1};
    vecs[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8044, 8'h00, 16'h8000, 1'b0};
    vecs[5] = '{16'h1000, 16'h8000, 16'h7FFF, 16'h0000, 8'h10, 16'h0A00, 1'b0};

    do_reset();
    check("reset_pins", 32'(pins()), 32'h0);

    // First-step vectors: equality fires, saturation precedes compare, floor leak.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load_cfg(vecs[i].er, vecs[i].tau, vecs[i].vth, vecs[i].vinit, i == 0);
      check("post_load", 32'(pins()),
            {8'h00, vecs[i].vinit[15:8], vecs[i].vinit[7:1], 1'b0, 8'hFF});
      ui_in  = vecs[i].ui;
      uio_in = 8'($urandom);
      @(posedge clk); #1;
      check($sformatf("vec%0d_step", i), 32'({uo_out, uio_out}),
            {16'h0, vecs[i].exp_v[15:8], vecs[i].exp_v[7:1], vecs[i].exp_spk});
    end

    // Decay to rest from V_INIT with zero input.
    do_reset();
    load_cfg(16'hC5FF, 16'h018E, 16'h3C00, 16'hE001, 1'b0);
    mono_ok   = 1'b1;
    any_spike = 1'b0;
    prev_v    = {uo_out, uio_out[7:1], 1'b0};
    for (int c = 0; c < 3000; c++) begin
      run_cycle(8'h00, "decay", ok);
      if (!ok) break;
      cur_v = {uo_out, uio_out[7:1], 1'b0};
      if ($signed(cur_v) > $signed(prev_v) || $signed(cur_v) < $signed(16'hC5FE)) mono_ok = 1'b0;
      if (uio_out[0]) any_spike = 1'b1;
      prev_v = cur_v;
    end
    check("decay_monotonic", 32'(mono_ok), 32'd1);
    check("decay_no_spike", 32'(any_spike), 32'd0);
    check("decay_at_rest", 32'(pins()), 32'h00C5FEFF);

    // Constant drive of 17.0: periodic one-cycle spikes, v back at rest.
    spikes   = 0;
    m_spikes = 0;
    for (int c = 0; c < 60; c++) begin
      run_cycle(8'h88, "drive", ok);
      if (uio_out[0]) begin
        spikes++;
        check("drive_spike_v", 32'({uo_out, uio_out[7:1]}), 32'({8'hC5, 7'h7F}));
      end
      if (m_spike != 0) m_spikes++;
    end
    check("drive_spike_count", 32'(spikes), 32'(m_spikes));
    check("drive_periodic", 32'(spikes >= 5), 32'd1);

    // Current ramp 0x00..0x38.
    for (int s = 0; s < 8; s++) run_cycle(8'(s * 8), "ramp", ok);

    // Random configurations and input currents.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      load_cfg(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h4000)),
               16'($urandom), 1'b0);
      check("rand_post_load", 32'(pins()), 32'(exp_pins(m_v, 0, 1'b1)));
      for (int c = 0; c < 300; c++) begin
        run_cycle(8'($urandom), "random", ok);
        if (!ok) break;
      end
    end

    // Reset while running clears everything and restarts the load sequence.
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun_reset_pins", 32'(pins()), 32'h0);
    rst    = 1'b0;
    ui_in  = 8'hFF;
    uio_in = 8'hFF;
    @(posedge clk); #1;
    check("midrun_reload_oe", 32'(uio_oe), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
